// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO master.
//   mdio_state_e    : frame sequencer states
//   MDIO_*          : fixed frame field encodings
//   *_BITS          : field lengths in MDC bit periods
//   mdio_next_phase : successor of a bit-carrying phase once its last bit ends
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  // ST + OP + PHYAD + REGAD
  localparam int unsigned HDR_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;

  function automatic mdio_state_e mdio_next_phase(input mdio_state_e s);
    mdio_state_e n;
    unique case (s)
      PRE:     n = HDR;
      HDR:     n = TA;
      TA:      n = DATA;
      DATA:    n = DONE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator. While enable is high, MDC is low for MDC_HALF clk cycles and then high for
// MDC_HALF cycles. When enable is low, the phase is reset so that every frame starts with a
// full low phase.
//   clk, rst : system clock, synchronous active-high reset
//   enable   : run MDC
//   mdc      : registered management clock
//   rise_stb : high in the clk cycle at whose end MDC goes 0->1 (sample point)
//   fall_stb : high in the clk cycle at whose end MDC goes 1->0 (drive point)
module mdio_clk_gen #(
  parameter int unsigned MDC_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned CntW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MDC_HALF - 1);

  logic [CntW-1:0] cnt_q;
  logic            mdc_q;
  logic            phase_end;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase_end = enable && (cnt_q == CntLast);
  assign rise_stb  = phase_end && !mdc_q;
  assign fall_stb  = phase_end && mdc_q;
  assign mdc       = mdc_q;

endmodule

// File: rtl/mdio_driver.sv
// Clause-22 MDIO management master. One start pulse runs one read or write frame:
// preamble, ST, OP, PHYAD, REGAD, TA, DATA. Also drives the PHY hardware reset pin.
//   clk, rst_n          : system clock, synchronous reset (active-high despite the name)
//   eth_mdc, eth_mdio   : PHY management clock and bidirectional data (Z when released)
//   eth_rst_n           : PHY reset, low only while rst_n is asserted
//   start, is_rd        : frame request (accepted in IDLE only) and direction
//   phy_addr, reg_addr  : frame addresses, latched with start
//   wr_data             : write payload, latched with start
//   rd_data             : last read result, updated by read frames only
//   o_vld               : one-cycle pulse when a frame completes
module mdio_driver
  import mdio_pkg::*;
#(
  parameter int unsigned MDC_HALF = 2,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        eth_mdc,
  inout  wire         eth_mdio,
  output logic        eth_rst_n,
  input  logic        start,
  input  logic        is_rd,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        o_vld
);

  localparam logic [5:0] PreLast = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

  mdio_state_e state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d, bit_last;
  logic        is_rd_q;
  logic [31:0] tx_q;
  logic [15:0] rx_q;
  logic [15:0] rd_data_q;
  logic        rst_pin_q;
  logic        mdc_en, rise_stb, fall_stb;
  logic        mdio_oe, mdio_out;

  assign mdc_en = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);

  mdio_clk_gen #(
    .MDC_HALF(MDC_HALF)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst_n),
    .enable  (mdc_en),
    .mdc     (eth_mdc),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_last  = '0;
    unique case (state_q)
      PRE:     bit_last = PreLast;
      HDR:     bit_last = 6'(HDR_BITS - 1);
      TA:      bit_last = 6'(TA_BITS - 1);
      DATA:    bit_last = 6'(DATA_BITS - 1);
      default: ;
    endcase
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = (PRE_LEN == 0) ? HDR : PRE;
          bit_cnt_d = '0;
        end
      end
      PRE, HDR, TA, DATA: begin
        // A bit ends on the MDC falling edge; phase changes line up with MDIO updates.
        if (fall_stb) begin
          if (bit_cnt_q == bit_last) begin
            state_d   = mdio_next_phase(state_q);
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      is_rd_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rst_pin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rst_pin_q <= 1'b1;
      if (state_q == IDLE && start) begin
        is_rd_q <= is_rd;
        tx_q    <= {MDIO_ST, (is_rd ? MDIO_OP_RD : MDIO_OP_WR), phy_addr, reg_addr, MDIO_TA_WR,
                    wr_data};
      end else if (fall_stb && (state_q == HDR || state_q == TA || state_q == DATA)) begin
        tx_q <= {tx_q[30:0], 1'b0};
      end
      if (rise_stb && state_q == DATA) begin
        rx_q <= {rx_q[14:0], eth_mdio};
      end
      // Load on entry to DONE so the word is already valid alongside o_vld.
      if (state_q == DATA && state_d == DONE && is_rd_q) begin
        rd_data_q <= rx_q;
      end
    end
  end

  always_comb begin
    mdio_oe  = 1'b0;
    mdio_out = 1'b1;
    unique case (state_q)
      PRE: begin
        mdio_oe  = 1'b1;
        mdio_out = 1'b1;
      end
      HDR: begin
        mdio_oe  = 1'b1;
        mdio_out = tx_q[31];
      end
      TA, DATA: begin
        mdio_oe  = !is_rd_q;
        mdio_out = tx_q[31];
      end
      default: ;
    endcase
  end

  assign eth_mdio  = mdio_oe ? mdio_out : 1'bz;
  assign eth_rst_n = rst_pin_q;
  assign rd_data   = rd_data_q;
  assign o_vld     = (state_q == DONE);

endmodule

// File: tb/tb_mdio_driver.sv
// Self-checking bench for mdio_driver: a PHY model on the MDIO pins, a scoreboard of
// expected completions (cycle, rd_data, sampled MDIO stream) and per-cycle pin monitors.
module tb_mdio_driver;

  localparam int unsigned MDC_HALF = 2;
  localparam int unsigned PRE_LEN  = 32;
  localparam int          LAT      = 1 + int'((PRE_LEN + 32) * 2 * MDC_HALF);

  typedef struct {
    int          due;
    logic [15:0] rd;
    logic [63:0] stream;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_rd = 1'b0;
  logic [4:0]  phy_addr = '0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] wr_data = '0;
  logic        eth_mdc, eth_rst_n, o_vld;
  logic [15:0] rd_data;
  wire         eth_mdio;

  // PHY side of the bus
  logic        phy_oe = 1'b0;
  logic        phy_bit = 1'b0;
  logic        phy_rd = 1'b0;
  logic [15:0] phy_data = '0;
  int          seq = 0;
  int          seen = 0;
  int          k = 0;
  logic [63:0] stream = '0;

  // Scoreboard and monitors
  exp_t        q[$];
  logic [15:0] exp_rd = '0;
  int          cyc = 0;
  int          act_start = 0;
  int          act_end = 0;
  bit          mon_on = 1'b0;
  bit          prev_in = 1'b0;
  logic        prev_mdc = 1'b0;
  logic        prev_mdio = 1'b1;
  int          run = 0;
  int          edge_viol = 0;
  int          duty_viol = 0;
  int          idle_viol = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pullup mdio_pu (eth_mdio);
  assign eth_mdio = phy_oe ? phy_bit : 1'bz;

  mdio_driver #(
    .MDC_HALF(MDC_HALF),
    .PRE_LEN (PRE_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .eth_mdc  (eth_mdc),
    .eth_mdio (eth_mdio),
    .eth_rst_n(eth_rst_n),
    .start    (start),
    .is_rd    (is_rd),
    .phy_addr (phy_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .o_vld    (o_vld)
  );

  // PHY samples on MDC rise; k counts rises within the current frame.
  always @(posedge eth_mdc) begin
    stream <= {stream[62:0], eth_mdio};
    if (seq != seen) begin
      seen <= seq;
      k    <= 1;
    end else begin
      k <= k + 1;
    end
  end

  // PHY drives on MDC fall: TA bit 2 = 0, then the 16 data bits.
  always @(negedge eth_mdc) begin
    if (phy_rd && k >= 47 && k <= 63) begin
      phy_oe  <= 1'b1;
      phy_bit <= (k == 47) ? 1'b0 : phy_data[63-k];
    end else begin
      phy_oe <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic in_frame;
    logic mdio_s;
    exp_t e;
    @(negedge clk);
    cyc++;
    in_frame = (cyc > act_start) && (cyc < act_end);
    mdio_s   = eth_mdio;
    if (mon_on) begin
      if (in_frame && prev_in) begin
        if (mdio_s !== prev_mdio && !(prev_mdc === 1'b1 && eth_mdc === 1'b0)) edge_viol++;
        if (eth_mdc !== prev_mdc) begin
          if (run != int'(MDC_HALF)) duty_viol++;
          run = 1;
        end else begin
          run++;
        end
      end else begin
        run = 1;
      end
      if (!in_frame && (eth_mdc !== 1'b0 || mdio_s !== 1'b1)) idle_viol++;
      if (o_vld === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_vld", 64'(o_vld), 64'(0));
        end else begin
          e = q.pop_front();
          check("vld_cycle", 64'(cyc), 64'(e.due));
          check("rd_data", 64'(rd_data), 64'(e.rd));
          check("mdio_stream", stream, e.stream);
        end
      end
    end
    prev_in   = in_frame;
    prev_mdc  = eth_mdc;
    prev_mdio = mdio_s;
  endtask

  task automatic issue(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] pd, input bit accept);
    exp_t e;
    is_rd    = rd;
    phy_addr = pa;
    reg_addr = ra;
    wr_data  = wd;
    start    = 1'b1;
    if (accept) begin
      e.due = cyc + LAT;
      e.rd  = rd ? pd : exp_rd;
      if (rd) exp_rd = pd;
      e.stream = rd ? {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 2'b10, pd}
                    : {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
      q.push_back(e);
      act_start = cyc;
      act_end   = cyc + LAT;
      phy_rd    = rd;
      phy_data  = pd;
      seq++;
    end
    tick();
    start = 1'b0;
    // Scramble the request inputs; the frame must use its latched copies.
    is_rd    = ~rd;
    phy_addr = ~pa;
    reg_addr = ~ra;
    wr_data  = ~wd;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      check("timeout_pending", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  initial begin
    exp_t dropped;
    repeat (3) tick();
    check("reset_mdc", 64'(eth_mdc), 64'(0));
    check("reset_mdio_released", 64'(eth_mdio), 64'(1));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    check("reset_vld", 64'(o_vld), 64'(0));
    check("reset_phy_rst", 64'(eth_rst_n), 64'(0));
    rst_n = 1'b0;
    tick();
    check("phy_rst_released", 64'(eth_rst_n), 64'(1));
    mon_on = 1'b1;
    repeat (2) tick();

    // Read: PHY 6, reg 4, PHY returns A5C3
    issue(1'b1, 5'd6, 5'd4, 16'h0000, 16'hA5C3, 1'b1);
    wait_done(LAT + 20);
    repeat (3) tick();

    // Write: PHY 6, reg 4, data 12; rd_data must keep A5C3
    issue(1'b0, 5'd6, 5'd4, 16'd12, 16'h0000, 1'b1);
    wait_done(LAT + 20);
    check("rd_data_after_write", 64'(rd_data), 64'(16'hA5C3));
    repeat (3) tick();

    // Busy: a second start 70 clk into the frame is ignored
    issue(1'b1, 5'd17, 5'd9, 16'h0000, 16'h3C5A, 1'b1);
    repeat (69) tick();
    issue(1'b0, 5'd3, 5'd30, 16'hFFFF, 16'h0000, 1'b0);
    wait_done(LAT + 20);
    repeat (LAT + 10) tick();

    // Reset in the middle of the header
    issue(1'b1, 5'd6, 5'd4, 16'h0000, 16'h0F0F, 1'b1);
    repeat (4 * 37 + 1) tick();
    rst_n   = 1'b1;
    dropped = q.pop_back();
    exp_rd  = 16'h0000;
    act_end = cyc + 1;
    tick();
    check("abort_mdc", 64'(eth_mdc), 64'(0));
    check("abort_mdio_released", 64'(eth_mdio), 64'(1));
    check("abort_vld", 64'(o_vld), 64'(0));
    check("abort_rd_data", 64'(rd_data), 64'(0));
    check("abort_phy_rst", 64'(eth_rst_n), 64'(0));
    rst_n = 1'b0;
    tick();
    check("abort_phy_rst_release", 64'(eth_rst_n), 64'(1));
    repeat (2) tick();
    issue(1'b1, 5'd6, 5'd4, 16'h0000, 16'h1234, 1'b1);
    wait_done(LAT + 20);

    // Back-to-back: start in the first IDLE cycle after DONE
    repeat (3) tick();
    issue(1'b0, 5'd1, 5'd2, 16'hBEEF, 16'h0000, 1'b1);
    wait_done(LAT + 20);
    tick();
    issue(1'b1, 5'd31, 5'd0, 16'h0000, 16'h8001, 1'b1);
    wait_done(LAT + 20);
    repeat (LAT + 10) tick();

    check("mdio_edge_violations", 64'(edge_viol), 64'(0));
    check("mdc_duty_violations", 64'(duty_viol), 64'(0));
    check("idle_pin_violations", 64'(idle_viol), 64'(0));
    check("pending_at_end", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
